// File: rtl/def.sv
// ALU operation codes shared by the datapath and the controllers.
package def_pkg;
  localparam logic [3:0] ALU_OPCODE_ADD = 4'b0000;
  localparam logic [3:0] ALU_OPCODE_SUB = 4'b1000;
  localparam logic [3:0] ALU_OPCODE_SLT = 4'b0010;
  localparam logic [3:0] ALU_OPCODE_OR  = 4'b0110;
  localparam logic [3:0] ALU_OPCODE_AND = 4'b0111;
endpackage

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle controller: states, mux selects, opcodes.
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, TRAP
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational IR decode: state after DECODE, immediate format,
// R-type ALU operation and a legality flag.
module mc_instr_decoder
  import mc_pkg::*;
  import def_pkg::*;
(
  input  logic [31:0] instr_i,
  output state_t      next_o,
  output logic [2:0]  imm_src_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        legal_o
);
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    next_o     = TRAP;
    imm_src_o  = IMM_I;
    alu_ctrl_o = ALU_OPCODE_ADD;
    legal_o    = 1'b0;
    unique case (op)
      OP_LOAD: if (f3 == 3'b100) begin
        next_o  = MEMADR;
        legal_o = 1'b1;
      end
      OP_STORE: if (f3 == 3'b000) begin
        next_o    = MEMADR;
        imm_src_o = IMM_S;
        legal_o   = 1'b1;
      end
      OP_R: begin
        next_o  = EXECR;
        legal_o = 1'b1;
        unique case ({f7, f3})
          10'b0000000_000: alu_ctrl_o = ALU_OPCODE_ADD;
          10'b0100000_000: alu_ctrl_o = ALU_OPCODE_SUB;
          10'b0000000_111: alu_ctrl_o = ALU_OPCODE_AND;
          10'b0000000_110: alu_ctrl_o = ALU_OPCODE_OR;
          10'b0000000_010: alu_ctrl_o = ALU_OPCODE_SLT;
          default: begin
            next_o  = TRAP;
            legal_o = 1'b0;
          end
        endcase
      end
      OP_I: if (f3 == 3'b000) begin
        next_o  = EXECI;
        legal_o = 1'b1;
      end
      OP_BR: if (f3 == 3'b001) begin
        next_o    = BRANCH;
        imm_src_o = IMM_B;
        legal_o   = 1'b1;
      end
      OP_JAL: begin
        next_o    = JAL;
        imm_src_o = IMM_J;
        legal_o   = 1'b1;
      end
      OP_JALR: if (f3 == 3'b000) begin
        next_o  = JALR1;
        legal_o = 1'b1;
      end
      OP_AUIPC: begin
        next_o    = ALUWB;
        imm_src_o = IMM_U;
        legal_o   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core; one ALU and one memory
// port are shared across the cycles of each instruction.
module multicycle_controller
  import mc_pkg::*;
  import def_pkg::*;
#(
  parameter bit RESET_TRAP_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUctrl,
  output logic [2:0]  ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic        instr_done,
  output logic        illegal
);
  state_t     state_q, state_d;
  state_t     dec_next;
  logic [2:0] dec_imm;
  logic [3:0] dec_alu;
  logic       dec_legal;

  mc_instr_decoder u_dec (
    .instr_i    (Instr),
    .next_o     (dec_next),
    .imm_src_o  (dec_imm),
    .alu_ctrl_o (dec_alu),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= (!RESET_TRAP_CLEAR && state_q == TRAP) ? TRAP : FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUctrl    = ALU_OPCODE_ADD;
    ImmSrc     = IMM_I;
    ResultSrc  = RES_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // Every strobe stays low in a reset cycle, even mid-access.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = dec_imm;
          state_d = dec_legal ? dec_next : TRAP;
        end
        MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = dec_imm;
          state_d = Instr[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
          if (mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUctrl = dec_alu;
          state_d = ALUWB;
        end
        EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          state_d = ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = SRCA_RS1;
          ALUctrl    = ALU_OPCODE_SUB;
          PCWrite    = ~Zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          state_d = ALUWB;
        end
        JALR1: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = dec_imm;
          state_d = JALR2;
        end
        JALR2: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          state_d = ALUWB;
        end
        TRAP: illegal = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level model expands each
// instruction into its expected per-cycle strobe pattern.
module tb_multicycle_controller;
  import def_pkg::*;

  typedef struct packed {
    logic       req, wr, adr, irw, pcw, rgw;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] rs;
    logic       done, ill;
  } exp_t;

  typedef struct {
    logic        rst, mr, z;
    logic [31:0] ins;
    int          idx;
    exp_t        e;
    string       tag;
  } step_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] Instr = '0;
  logic        Zero = 0;
  logic        mem_ready = 0;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUctrl;
  logic [2:0]  ImmSrc;
  logic        instr_done, illegal;

  int    checks = 0;
  int    passes = 0;
  int    done_idx = 0;
  step_t cur;
  bit    cur_v = 0;
  step_t plan_q[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
    .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic void check(string n, int got, int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got %0d want %0d", n, got, want);
  endfunction

  always @(negedge clk) begin
    if (cur_v) begin
      exp_t act;
      act = '{MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
              ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc,
              instr_done, illegal};
      checks++;
      if (act === cur.e) passes++;
      else $display("FAIL %s cyc%0d got %h want %h",
                    cur.tag, cur.idx, act, cur.e);
      if (instr_done === 1'b1) done_idx = cur.idx;
    end
  end

  // 0 illegal, 1 addi, 2 lbu, 3 sb, 4 R-type, 5 bne, 6 jal, 7 jalr, 8 auipc
  function automatic int kind(logic [31:0] i);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (op == 7'h13 && f3 == 0) return 1;
    if (op == 7'h03 && f3 == 4) return 2;
    if (op == 7'h23 && f3 == 0) return 3;
    if (op == 7'h33 && f7 == 0 && f3 inside {0, 2, 6, 7}) return 4;
    if (op == 7'h33 && f7 == 7'h20 && f3 == 0) return 4;
    if (op == 7'h63 && f3 == 1) return 5;
    if (op == 7'h6F) return 6;
    if (op == 7'h67 && f3 == 0) return 7;
    if (op == 7'h17) return 8;
    return 0;
  endfunction

  function automatic logic [3:0] r_alu(logic [31:0] i);
    if (i[30]) return ALU_OPCODE_SUB;
    case (i[14:12])
      3'd7: return ALU_OPCODE_AND;
      3'd6: return ALU_OPCODE_OR;
      3'd2: return ALU_OPCODE_SLT;
      default: return ALU_OPCODE_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(int k);
    case (k)
      3: return 3'd1;
      5: return 3'd2;
      8: return 3'd3;
      6: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic void push(logic r, logic mr, logic z,
                               logic [31:0] ins, exp_t e, string tag);
    step_t s;
    s.rst = r; s.mr = mr; s.z = z; s.ins = ins;
    s.idx = plan_q.size() + 1; s.e = e; s.tag = tag;
    plan_q.push_back(s);
  endfunction

  function automatic exp_t wb();
    exp_t e = '0;
    e.rgw = 1; e.done = 1;
    return e;
  endfunction

  function automatic void plan(string tag, logic [31:0] ins,
                               int fw, int mw, logic z);
    exp_t e;
    int   k = kind(ins);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.req = 1; e.sb = 2; e.rs = 2;
      e.irw = (i == fw); e.pcw = (i == fw);
      push(0, i == fw, z, ins, e, tag);
    end
    e = '0; e.sa = 1; e.sb = 1; e.imm = imm_of(k);
    push(0, 1, z, ins, e, tag);
    case (k)
      0: for (int i = 0; i < 12; i++) begin
        e = '0; e.ill = 1;
        push(0, 1, z, ins, e, tag);
      end
      1: begin
        e = '0; e.sa = 2; e.sb = 1;
        push(0, 1, z, ins, e, tag);
        push(0, 1, z, ins, wb(), tag);
      end
      2, 3: begin
        e = '0; e.sa = 2; e.sb = 1; e.imm = imm_of(k);
        push(0, 1, z, ins, e, tag);
        for (int i = 0; i <= mw; i++) begin
          e = '0; e.req = 1; e.adr = 1;
          e.wr = (k == 3); e.done = (k == 3 && i == mw);
          push(0, i == mw, z, ins, e, tag);
        end
        if (k == 2) begin
          e = wb(); e.rs = 1;
          push(0, 1, z, ins, e, tag);
        end
      end
      4: begin
        e = '0; e.sa = 2; e.alu = r_alu(ins);
        push(0, 1, z, ins, e, tag);
        push(0, 1, z, ins, wb(), tag);
      end
      5: begin
        e = '0; e.sa = 2; e.alu = ALU_OPCODE_SUB;
        e.pcw = ~z; e.done = 1;
        push(0, 1, z, ins, e, tag);
      end
      6, 7: begin
        if (k == 7) begin
          e = '0; e.sa = 2; e.sb = 1;
          push(0, 1, z, ins, e, tag);
        end
        e = '0; e.sa = 1; e.sb = 2; e.pcw = 1;
        push(0, 1, z, ins, e, tag);
        push(0, 1, z, ins, wb(), tag);
      end
      default: push(0, 1, z, ins, wb(), tag);
    endcase
  endfunction

  task automatic run(string tag, logic [31:0] ins, int fw, int mw,
                     logic z, int lat, int rst_at);
    plan_q.delete();
    plan(tag, ins, fw, mw, z);
    if (rst_at > 0) begin
      while (plan_q.size() >= rst_at) void'(plan_q.pop_back());
      push(1, 1, z, ins, '0, {tag, "_rst"});
    end else begin
      check({tag, "_model_len"}, plan_q.size(), lat + fw + mw);
    end
    done_idx = 0;
    foreach (plan_q[i]) begin
      @(posedge clk); #1;
      rst = plan_q[i].rst; mem_ready = plan_q[i].mr;
      Zero = plan_q[i].z; Instr = plan_q[i].ins;
      cur = plan_q[i]; cur_v = 1;
    end
    @(negedge clk); #1;
    check({tag, "_done_cycle"}, done_idx, rst_at > 0 ? 0 : lat + fw + mw);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cur.rst = 1; cur.idx = i + 1; cur.e = '0; cur.tag = "reset";
      cur_v = 1; mem_ready = 1;
    end
    @(negedge clk); #1;
    check("reset_memreq", int'(MemReq), 0);
    @(posedge clk); #1;
    rst = 0; mem_ready = 0; cur_v = 0;
    @(negedge clk); #1;
    check("post_reset_fetch_req", int'(MemReq), 1);
    check("post_reset_no_irw", int'(IRWrite), 0);

    run("addi",    32'h00500093, 0, 0, 0, 4, 0);
    run("bne_nz",  32'h00209463, 0, 0, 0, 3, 0);
    run("bne_z",   32'h00209463, 0, 0, 1, 3, 0);
    run("add_fw3", 32'h002081B3, 3, 0, 0, 4, 0);
    run("sb_mw2",  32'h00110023, 0, 2, 0, 4, 0);
    run("sub",     32'h402081B3, 0, 0, 0, 4, 0);
    run("and",     32'h0020F1B3, 0, 0, 0, 4, 0);
    run("or",      32'h0020E1B3, 1, 0, 0, 4, 0);
    run("slt",     32'h0020A1B3, 0, 0, 0, 4, 0);
    run("lbu_mw1", 32'h00404083, 0, 1, 0, 5, 0);
    run("jal",     32'h008000EF, 0, 0, 0, 4, 0);
    run("jalr",    32'h000080E7, 0, 0, 0, 5, 0);
    run("auipc",   32'h00001097, 0, 0, 0, 3, 0);
    run("bad_f7",  32'h022081B3, 0, 0, 0, 0, 4);
    run("trap",    32'hFFFFFFFF, 0, 0, 0, 0, 13);
    check("trap_cleared", int'(illegal), 0);
    run("lbu_rst", 32'h00404083, 0, 1, 0, 0, 4);
    run("addi_after", 32'h00500093, 0, 0, 0, 4, 0);
    cur_v = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
